// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-stage request/response plus the data RAM port.
// master = pipeline + RAM side, slave = store buffer.
interface store_buffer_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_o;
  logic        sb_empty_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic        ram_re_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i,
    output mem_sel_i, mem_data_i, ram_data_i,
    input  mem_data_o, stallreq_o, sb_empty_o,
    input  ram_ce_o, ram_we_o, ram_re_o,
    input  ram_addr_o, ram_sel_o, ram_data_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i,
    input  mem_sel_i, mem_data_i, ram_data_i,
    output mem_data_o, stallreq_o, sb_empty_o,
    output ram_ce_o, ram_we_o, ram_re_o,
    output ram_addr_o, ram_sel_o, ram_data_o
  );
endinterface

// File: rtl/store_buffer.sv
// In-order write-back store buffer between MEM and the byte-lane data RAM.
// Drains when MEM leaves the port idle; loads see forwarded buffered bytes.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } sb_entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  sb_entry_t        entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty_q;

  logic             full, empty;
  logic             drain, ld, st;
  logic [PTR_W-1:0] idx;
  logic [31:0]      merged;
  logic             unused_addr;

  assign unused_addr = ^sb.mem_addr_i[1:0];

  assign full  = count_q == FULL_CNT;
  assign empty = count_q == '0;

  // rst gates everything so outputs are quiet while held in reset
  assign drain = rst && !empty && (!sb.mem_ce_i || full);
  assign ld    = rst && sb.mem_ce_i && !sb.mem_we_i && !full;
  assign st    = rst && sb.mem_ce_i && sb.mem_we_i && !full;

  assign sb.stallreq_o = rst && sb.mem_ce_i && full;
  assign sb.sb_empty_o = empty_q;

  // oldest to youngest, so the youngest matching byte lands last
  always_comb begin
    merged = sb.ram_data_i;
    idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((PTR_W+1)'(i) < count_q &&
          entry_q[idx].addr == sb.mem_addr_i[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (entry_q[idx].sel[b])
            merged[8*b +: 8] = entry_q[idx].data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    sb.ram_ce_o   = 1'b0;
    sb.ram_we_o   = 1'b0;
    sb.ram_re_o   = 1'b0;
    sb.ram_addr_o = '0;
    sb.ram_sel_o  = '0;
    sb.ram_data_o = '0;
    sb.mem_data_o = '0;
    if (drain) begin
      sb.ram_ce_o   = 1'b1;
      sb.ram_we_o   = 1'b1;
      sb.ram_addr_o = {entry_q[head_q].addr, 2'b00};
      sb.ram_sel_o  = entry_q[head_q].sel;
      sb.ram_data_o = entry_q[head_q].data;
    end else if (ld) begin
      sb.ram_ce_o   = 1'b1;
      sb.ram_re_o   = 1'b1;
      sb.ram_addr_o = {sb.mem_addr_i[31:2], 2'b00};
      sb.ram_sel_o  = 4'hF;
      sb.mem_data_o = merged;
    end
  end

  // st and drain are mutually exclusive: st needs !full, drain then needs !ce
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d  = head_q + PTR_ONE;
      count_d = count_q - CNT_ONE;
    end
    if (st) begin
      tail_d  = tail_q + PTR_ONE;
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
    end
  end

  always_ff @(posedge clk) begin
    if (st)
      entry_q[tail_q] <= {sb.mem_addr_i[31:2], sb.mem_sel_i, sb.mem_data_i};
  end

endmodule
